// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory access FSM, load alignment and
// extension, store strobe generation, and stall/exception signalling toward writeback.
module memory_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic        MemWriteE,
    input  logic [2:0]  Funct3E,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RdE,
    input  logic [31:0] PCPlus4E,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [31:0] ALUResultM,
    output logic [31:0] ReadDataM,
    output logic [4:0]  RdM,
    output logic [31:0] PCPlus4M,
    output logic        ExcM,
    output logic        o_dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {ACCESS = 1'b0, WAIT_RSP = 1'b1} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_clr;
    logic          w_load_done;

    logic        r_reg_write;
    logic [1:0]  r_result_src;
    logic        r_mem_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_alu_result;
    logic [31:0] r_write_data;
    logic [4:0]  r_rd;
    logic [31:0] r_pc_plus4;

    logic        w_is_load;
    logic        w_mem_op;
    logic        w_bad;
    logic [1:0]  w_lane;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ACCESS;
            r_cnt        <= '0;
            r_reg_write  <= 1'b0;
            r_result_src <= 2'b00;
            r_mem_write  <= 1'b0;
            r_funct3     <= 3'b000;
            r_alu_result <= 32'h0;
            r_write_data <= 32'h0;
            r_rd         <= 5'h0;
            r_pc_plus4   <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (r_state == WAIT_RSP)
                r_cnt <= r_cnt + CW'(1);
            if (!StallM) begin
                r_reg_write  <= RegWriteE;
                r_result_src <= ResultSrcE;
                r_mem_write  <= MemWriteE;
                r_funct3     <= Funct3E;
                r_alu_result <= ALUResultE;
                r_write_data <= WriteDataE;
                r_rd         <= RdE;
                r_pc_plus4   <= PCPlus4E;
            end
        end
    end

    assign w_is_load = (r_result_src == 2'b01);
    assign w_mem_op  = r_mem_write | w_is_load;
    assign w_lane    = r_alu_result[1:0];
    assign w_bad     = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111)
                     || ((r_funct3[1:0] == 2'b01) && w_lane[0])
                     || ((r_funct3[1:0] == 2'b10) && (w_lane != 2'b00));

    // Store wins if both store and load-select are set; a load only sees ready once.
    always_comb begin
        w_next_state   = r_state;
        StallM         = 1'b0;
        ExcM           = 1'b0;
        dmem_req_valid = 1'b0;
        w_cnt_clr      = 1'b0;
        w_load_done    = 1'b0;
        case (r_state)
            ACCESS: begin
                if (w_mem_op) begin
                    if (w_bad) begin
                        ExcM = 1'b1;
                    end else begin
                        dmem_req_valid = 1'b1;
                        if (r_mem_write) begin
                            StallM = ~dmem_req_ready;
                        end else begin
                            StallM = 1'b1;
                            if (dmem_req_ready) begin
                                w_next_state = WAIT_RSP;
                                w_cnt_clr    = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    w_load_done  = 1'b1;
                    w_next_state = ACCESS;
                end else if (r_cnt == CW'(TIMEOUT)) begin
                    ExcM         = 1'b1;
                    w_next_state = ACCESS;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: w_next_state = ACCESS;
        endcase
    end

    assign w_shift = dmem_rdata >> {w_lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_fmt = 32'h0;
        case (r_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b010:  w_fmt = dmem_rdata;
            3'b100:  w_fmt = {24'h0, w_byte};
            3'b101:  w_fmt = {16'h0, w_half};
            default: w_fmt = 32'h0;
        endcase
    end

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = r_write_data;
        case (r_funct3[1:0])
            2'b00: begin
                dmem_wstrb = 4'b0001 << w_lane;
                dmem_wdata = {4{r_write_data[7:0]}};
            end
            2'b01: begin
                dmem_wstrb = w_lane[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{r_write_data[15:0]}};
            end
            2'b10:   dmem_wstrb = 4'b1111;
            default: dmem_wstrb = 4'b0000;
        endcase
        if (!r_mem_write || w_bad)
            dmem_wstrb = 4'b0000;
    end

    assign dmem_addr   = {r_alu_result[31:2], 2'b00};
    assign dmem_we     = r_mem_write;
    assign RegWriteM   = r_reg_write & ~StallM & ~ExcM;
    assign ResultSrcM  = r_result_src;
    assign ALUResultM  = r_alu_result;
    assign ReadDataM   = w_load_done ? w_fmt : 32'h0;
    assign RdM         = r_rd;
    assign PCPlus4M    = r_pc_plus4;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios then random operations, each checked
// cycle by cycle against a transaction-level model of the access.
module tb_memory_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic [2:0]  Funct3E;
  logic [31:0] ALUResultE;
  logic [31:0] WriteDataE;
  logic [4:0]  RdE;
  logic [31:0] PCPlus4E;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        ExcM;
  logic        o_dbg_state;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .RdE(RdE), .PCPlus4E(PCPlus4E),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M), .ExcM(ExcM), .o_dbg_state(o_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_bad(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (addr % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz;
    logic [31:0] v, mask;
    sz = acc_size(f3);
    v = rdata >> (8 * (addr % 4));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v = v & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int lane, sz;
    s = 4'b0000;
    lane = addr % 4;
    sz = acc_size(f3);
    for (int b = 0; b < 4; b++)
      if (b >= lane && b < lane + sz) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    int sz;
    sz = acc_size(f3);
    for (int b = 0; b < 4; b++) d[8 * b +: 8] = wd[8 * (b % sz) +: 8];
    return d;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_e(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4);
    RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; Funct3E = f3;
    ALUResultE = alu; WriteDataE = wd; RdE = rd; PCPlus4E = pc4;
  endtask

  task automatic bubble();
    drive_e(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, plays the memory side, checks every cycle it occupies M,
  // then checks one trailing bubble cycle with random bus noise.
  task automatic run_op(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int rdy_dly, input int rsp_wait, input logic [31:0] rdata);
    logic is_store, is_load, bad, tmo, done;
    logic [31:0] pc4, wb_exp;
    int last;
    pc4 = $urandom;
    is_store = mw;
    is_load = !mw && (rs == 2'b01);
    bad = (is_store || is_load) && is_bad(f3, addr);
    tmo = is_load && !bad && (rsp_wait > TO);
    exp_q.push_back((is_load && !bad && !tmo) ? load_val(f3, addr, rdata) : 32'h0);
    drive_e(rw, rs, mw, f3, addr, wd, rd, pc4);
    next_cycle();
    bubble();
    chk("rd", {27'h0, RdM}, {27'h0, rd});
    chk("alu_m", ALUResultM, addr);
    chk("pc4_m", PCPlus4M, pc4);
    chk("rsrc_m", {30'h0, ResultSrcM}, {30'h0, rs});
    if (!(is_store || is_load) || bad) begin
      dmem_req_ready = 1'($urandom); dmem_rvalid = 1'($urandom); #1;
      wb_exp = exp_q.pop_front();
      chk("stall_nm", {31'h0, StallM}, 32'h0);
      chk("exc_nm", {31'h0, ExcM}, {31'h0, bad});
      chk("rw_nm", {31'h0, RegWriteM}, {31'h0, rw && !bad});
      chk("req_nm", {31'h0, dmem_req_valid}, 32'h0);
      chk("rdata_nm", ReadDataM, wb_exp);
      next_cycle();
    end else begin
      for (int c = 0; c <= rdy_dly; c++) begin
        dmem_req_ready = (c == rdy_dly); dmem_rvalid = 1'($urandom); #1;
        chk("req_v", {31'h0, dmem_req_valid}, 32'h1);
        chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("req_we", {31'h0, dmem_we}, {31'h0, is_store});
        chk("req_strb", {28'h0, dmem_wstrb}, {28'h0, is_store ? store_strb(f3, addr) : 4'h0});
        if (is_store) chk("req_wdata", dmem_wdata, store_data(f3, wd));
        chk("acc_stall", {31'h0, StallM}, {31'h0, is_load || (c < rdy_dly)});
        chk("acc_rw", {31'h0, RegWriteM}, {31'h0, is_store && rw && (c == rdy_dly)});
        chk("acc_exc", {31'h0, ExcM}, 32'h0);
        if (is_store && c == rdy_dly) begin
          wb_exp = exp_q.pop_front();
          chk("st_rdata", ReadDataM, wb_exp);
        end
        next_cycle();
      end
      if (is_load) begin
        last = tmo ? TO : rsp_wait;
        for (int k = 0; k <= last; k++) begin
          dmem_req_ready = 1'($urandom);
          dmem_rvalid = (k == rsp_wait);
          dmem_rdata = (k == rsp_wait) ? rdata : $urandom;
          #1;
          done = (k == last);
          chk("w_req", {31'h0, dmem_req_valid}, 32'h0);
          chk("w_stall", {31'h0, StallM}, {31'h0, !done});
          chk("w_exc", {31'h0, ExcM}, {31'h0, done && tmo});
          chk("w_rw", {31'h0, RegWriteM}, {31'h0, done && !tmo && rw});
          if (done) begin
            wb_exp = exp_q.pop_front();
            chk("w_rdata", ReadDataM, wb_exp);
          end else begin
            chk("w_rdata0", ReadDataM, 32'h0);
          end
          next_cycle();
        end
      end
    end
    dmem_req_ready = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = $urandom; #1;
    chk("bub_stall", {31'h0, StallM}, 32'h0);
    chk("bub_rw", {31'h0, RegWriteM}, 32'h0);
    chk("bub_exc", {31'h0, ExcM}, 32'h0);
    chk("bub_rdata", ReadDataM, 32'h0);
    chk("bub_req", {31'h0, dmem_req_valid}, 32'h0);
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rs;
    logic mw;
    int kind;
    rst = 1'b1;
    bubble();
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'h0, StallM}, 32'h0);
    chk("rst_exc", {31'h0, ExcM}, 32'h0);
    chk("rst_rw", {31'h0, RegWriteM}, 32'h0);
    chk("rst_req", {31'h0, dmem_req_valid}, 32'h0);
    chk("rst_alu", ALUResultM, 32'h0);
    chk("rst_rd", {27'h0, RdM}, 32'h0);
    chk("rst_strb", {28'h0, dmem_wstrb}, 32'h0);
    chk("rst_state", {31'h0, o_dbg_state}, 32'h0);

    // directed scenarios
    run_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
    run_op(1'b0, 2'b00, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0, 2, 0, 32'h0);
    run_op(1'b1, 2'b01, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd7, 0, 2, 32'h8001_0000);
    run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd8, 0, 0, 32'h0);
    run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9, 1, 20, 32'h1111_2222);
    run_op(1'b1, 2'b10, 1'b0, 3'b000, 32'h0000_0040, 32'h0, 5'd1, 0, 0, 32'h0);
    run_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0302, 32'hCAFE_BEEF, 5'd0, 0, 0, 32'h0);
    run_op(1'b1, 2'b01, 1'b0, 3'b100, 32'h0000_0401, 32'h0, 5'd3, 0, TO, 32'h0000_9C00);

    // reset while waiting for a load response
    drive_e(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9, 32'h0000_0010);
    next_cycle();
    bubble();
    dmem_req_ready = 1'b1; #1;
    chk("rw_accept", {31'h0, StallM}, 32'h1);
    next_cycle();
    dmem_req_ready = 1'b0; #1;
    chk("rw_wait_state", {31'h0, o_dbg_state}, 32'h1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA; #1;
    chk("rw_state", {31'h0, o_dbg_state}, 32'h0);
    chk("rw_stall", {31'h0, StallM}, 32'h0);
    chk("rw_regw", {31'h0, RegWriteM}, 32'h0);
    chk("rw_rdata", ReadDataM, 32'h0);
    chk("rw_req", {31'h0, dmem_req_valid}, 32'h0);
    chk("rw_rd", {27'h0, RdM}, 32'h0);
    chk("rw_pc4", PCPlus4M, 32'h0);
    chk("rw_exc", {31'h0, ExcM}, 32'h0);
    next_cycle();
    dmem_rvalid = 1'b0; #1;
    chk("rw_after", {31'h0, RegWriteM}, 32'h0);

    // random operations
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 3);
      rs = (kind == 1) ? 2'b10 : (kind == 2) ? 2'b01 : 2'b00;
      mw = (kind == 3);
      run_op(1'($urandom), rs, mw, 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom_range(0, 6), $urandom);
    end

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
